ifm_feeder: RTL
===============

Name: ifm_feeder

Overview:
- Producer side of the IFM byte stream into the IFM shift buffer.
- Fetches a rectangular IFM tile from the IFM SRAM in raster order (row-major, base + row*stride + col).
- Drives ifm_input/ifm_read toward the buffer and honours the shared pipeline stall, so no byte is lost or duplicated.
- Sits between the layer controller (start/geometry) and the IFM shift buffer.

Parameters:
- ADDR_W, 12, SRAM word-address width; all address arithmetic is modulo 2^ADDR_W.
- CNT_W, 8, width of the row/column counters and geometry inputs.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a tile; sampled only in IDLE.
- base_addr  input  ADDR_W  address of tile element (0,0); latched on start.
- num_cols  input  CNT_W  bytes per row; latched on start.
- num_rows  input  CNT_W  rows per tile; latched on start.
- row_stride  input  ADDR_W  address step between rows; latched on start.
- stall  input  1  pipeline stall; a transfer occurs only when low.
- sram_cs  output  1  SRAM read enable.
- sram_addr  output  ADDR_W  SRAM read address.
- sram_rdata  input  8  SRAM read data, valid exactly 1 cycle after sram_cs.
- ifm_input  output  8 signed  byte to IFM buffer.
- ifm_read  output  1  ifm_input valid; transfer = ifm_read & ~stall at a clock edge.
- busy  output  1  tile in progress.
- done  output  1  one-cycle pulse after the final transfer.

Behaviour:
- Reset (async, rst_n low): state IDLE; sram_cs=0, sram_addr=0, ifm_input=0, ifm_read=0, busy=0, done=0; counters, skid register and geometry cleared. Reset mid-tile aborts with no further sram_cs or ifm_read.
- FSM IDLE -> FETCH -> DRAIN -> DONE -> IDLE.
  - IDLE: on start=1, latch geometry, col=row=0, row_base=base_addr, busy=1. If num_cols==0 or num_rows==0, go to DONE directly with no reads.
  - FETCH: issue a read (sram_cs=1, sram_addr=row_base+col) in any cycle with stall=0 and skid empty.
    - After each issue, col++. At col==num_cols-1: col=0, row++, row_base+=row_stride.
    - The issue of (num_rows-1, num_cols-1) moves the FSM to DRAIN.
  - DRAIN: no issues; wait until the output register and skid are empty.
  - DONE: done=1 for exactly one cycle, busy=0, return to IDLE.
- start is ignored while busy.
- sram_cs and sram_addr are combinational from state/counters; sram_cs is never high while stall=1.
- Data path: output register (ifm_input, ifm_read) plus a 1-entry skid register.
  - Return cycle (one after issue): if the output register is empty or transferring this edge, load sram_rdata into it; otherwise load the skid.
  - On a transfer edge, the skid (if full) moves to the output register; else ifm_read clears unless new data loads.
- While stall=1: ifm_input and ifm_read are held stable and no new reads issue. At most one in-flight byte lands in the skid.
- Latency, no stall: start at edge E0 -> first sram_cs in cycle after E0 -> ifm_read high 2 cycles after E0. Throughput is 1 byte/cycle.
- Byte order is strictly raster; every tile byte is transferred exactly once.
- done is asserted in the cycle after the last transfer edge.
- Simultaneous stall rise with a data return: data goes to the skid; nothing is lost.

Decomposition:
- Shared package: FSM state encoding (IDLE/FETCH/DRAIN/DONE), DATA_W=8 constant, default ADDR_W/CNT_W.
- One natural sub-module: ifm_skid_reg (output register + 1-entry skid, valid/stall hold logic). The address/counter FSM stays in ifm_feeder.

Test Plan:
- Basic tile: base=0x010, cols=4, rows=2, stride=8, no stall, SRAM[a]=a[7:0]. Required: addresses 0x010–0x013, 0x018–0x01B; bytes delivered in that order on 8 consecutive ifm_read cycles; done one cycle after the last.
- Stall mid-stream: same tile, stall high for 3 cycles starting the cycle after the 2nd issue. Required: ifm_input/ifm_read frozen during stall, no sram_cs while stalled, all 8 bytes delivered once each in order.
- Zero geometry: start with cols=0, rows=3. Required: no sram_cs, no ifm_read, done pulse 1 cycle after start, busy back to 0.
- Address wrap: ADDR_W=12, base=0xFFE, cols=4, rows=1. Required: addresses 0xFFE, 0xFFF, 0x000, 0x001.
- Start while busy: second start during FETCH. Required: ignored, first tile completes unchanged, exactly one done.
- Reset mid-tile: rst_n low after the 3rd transfer. Required: all outputs 0 immediately; a new start after release fetches from the new base correctly.

Source files
------------

// File: rtl/ifm_feeder_pkg.sv
// Shared types and defaults for the IFM feeder slice.
package ifm_feeder_pkg;

  localparam int DATA_W     = 8;
  localparam int ADDR_W_DEF = 12;
  localparam int CNT_W_DEF  = 8;

  // Tile sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/ifm_skid_reg.sv
// Output register plus one-entry skid buffer. Data returning from the SRAM
// lands in the output register when it is free (or emptying this edge),
// otherwise in the skid; the skid refills the output register on a transfer.
module ifm_skid_reg
  import ifm_feeder_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_vld_i,
  input  logic [W-1:0] in_data_i,
  input  logic         stall_i,
  output logic [W-1:0] out_data_o,
  output logic         out_vld_o,
  output logic         skid_full_o
);

  logic [W-1:0] out_q, out_d;
  logic         ov_q, ov_d;
  logic [W-1:0] sk_q, sk_d;
  logic         sv_q, sv_d;
  logic         xfer;

  assign xfer = ov_q & ~stall_i;

  // Next state: drain on transfer first, then place any returning byte.
  always_comb begin
    out_d = out_q;
    ov_d  = ov_q;
    sk_d  = sk_q;
    sv_d  = sv_q;
    if (xfer) begin
      if (sv_q) begin
        out_d = sk_q;
        ov_d  = 1'b1;
        sv_d  = 1'b0;
      end else begin
        ov_d  = 1'b0;
      end
    end
    if (in_vld_i) begin
      if (!ov_d) begin
        out_d = in_data_i;
        ov_d  = 1'b1;
      end else begin
        sk_d  = in_data_i;
        sv_d  = 1'b1;
      end
    end
  end

  // Output and skid registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      ov_q  <= 1'b0;
      sk_q  <= '0;
      sv_q  <= 1'b0;
    end else begin
      out_q <= out_d;
      ov_q  <= ov_d;
      sk_q  <= sk_d;
      sv_q  <= sv_d;
    end
  end

  assign out_data_o  = out_q;
  assign out_vld_o   = ov_q;
  assign skid_full_o = sv_q;

endmodule

// File: rtl/ifm_feeder.sv
// Raster-order tile fetcher: walks a rectangular IFM tile in SRAM and streams
// its bytes to the IFM shift buffer under the shared pipeline stall.
module ifm_feeder
  import ifm_feeder_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic [CNT_W-1:0]         num_cols,
  input  logic [CNT_W-1:0]         num_rows,
  input  logic [ADDR_W-1:0]        row_stride,
  input  logic                     stall,
  output logic                     sram_cs,
  output logic [ADDR_W-1:0]        sram_addr,
  input  logic [DATA_W-1:0]        sram_rdata,
  output logic signed [DATA_W-1:0] ifm_input,
  output logic                     ifm_read,
  output logic                     busy,
  output logic                     done
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  col_q, col_d;
  logic [CNT_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [CNT_W-1:0]  ncols_q, ncols_d;
  logic [CNT_W-1:0]  nrows_q, nrows_d;
  logic [ADDR_W-1:0] stride_q, stride_d;
  logic              rvalid_q;
  logic              skid_full;
  logic              issue;
  logic              drained;
  logic [DATA_W-1:0] out_data;

  // A read may only go out when the skid has room for a late stall.
  assign issue = (state_q == ST_FETCH) && !stall && !skid_full;

  // Pipeline is empty after this edge: nothing in flight, skid empty and the
  // output register either empty or handing off its byte now.
  assign drained = !rvalid_q && !skid_full && (!ifm_read || !stall);

  assign sram_cs   = issue;
  assign sram_addr = issue ? (row_base_q + ADDR_W'(col_q)) : '0;
  assign busy      = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
  assign done      = (state_q == ST_DONE);

  // Next-state logic: tile sequencing and raster counters.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    row_base_d = row_base_q;
    ncols_d    = ncols_q;
    nrows_d    = nrows_q;
    stride_d   = stride_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          ncols_d    = num_cols;
          nrows_d    = num_rows;
          stride_d   = row_stride;
          col_d      = '0;
          row_d      = '0;
          row_base_d = base_addr;
          if (num_cols == '0 || num_rows == '0) state_d = ST_DONE;
          else                                   state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (issue) begin
          if (col_q == ncols_q - CNT_W'(1)) begin
            col_d      = '0;
            row_d      = row_q + CNT_W'(1);
            row_base_d = row_base_q + stride_q;
            if (row_q == nrows_q - CNT_W'(1)) state_d = ST_DRAIN;
          end else begin
            col_d = col_q + CNT_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (drained) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, geometry and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      col_q      <= '0;
      row_q      <= '0;
      row_base_q <= '0;
      ncols_q    <= '0;
      nrows_q    <= '0;
      stride_q   <= '0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      row_base_q <= row_base_d;
      ncols_q    <= ncols_d;
      nrows_q    <= nrows_d;
      stride_q   <= stride_d;
    end
  end

  // Marks the cycle in which sram_rdata carries the byte read last cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rvalid_q <= 1'b0;
    else        rvalid_q <= issue;
  end

  ifm_skid_reg #(.W(DATA_W)) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_vld_i    (rvalid_q),
    .in_data_i   (sram_rdata),
    .stall_i     (stall),
    .out_data_o  (out_data),
    .out_vld_o   (ifm_read),
    .skid_full_o (skid_full)
  );

  assign ifm_input = out_data;

endmodule
